// File: rtl/calc_cmd_queue.sv
// calc_cmd_queue: tagged command FIFO, in-order dispatcher and result FIFO
// wrapped around a fixed-point and a floating-point ALU.

module fixed_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  operation,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        underflow,
    output logic        overflow
);
    logic [63:0] prod;
    logic [31:0] res_c;
    logic        dz_c;
    logic        of_c;
    logic        known;

    assign underflow = 1'b0;

    // Integer ops; codes 8-15 are unimplemented and never raise done
    always_comb begin
        prod  = 64'(operand_a) * 64'(operand_b);
        res_c = '0;
        dz_c  = 1'b0;
        of_c  = 1'b0;
        known = !operation[3];
        case (operation[2:0])
            3'd0: begin
                res_c = operand_a + operand_b;
                of_c  = (operand_a[31] == operand_b[31]) &&
                        (res_c[31] != operand_a[31]);
            end
            3'd1: begin
                res_c = operand_a - operand_b;
                of_c  = (operand_a[31] != operand_b[31]) &&
                        (res_c[31] != operand_a[31]);
            end
            3'd2: begin
                res_c = prod[31:0];
                of_c  = |prod[63:32];
            end
            3'd3: begin
                if (operand_b == '0) begin
                    res_c = '1;
                    dz_c  = 1'b1;
                end else begin
                    res_c = operand_a / operand_b;
                end
            end
            3'd4: res_c = operand_a & operand_b;
            3'd5: res_c = operand_a | operand_b;
            3'd6: res_c = operand_a ^ operand_b;
            default: res_c = operand_a << operand_b[4:0];
        endcase
    end

    // One-cycle latency: result and done register on the start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= start && known;
            if (start && known) begin
                result      <= res_c;
                div_by_zero <= dz_c;
                overflow    <= of_c;
            end
        end
    end
endmodule

module fp_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  operation,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        underflow,
    output logic        overflow
);
    logic [23:0]       ma;
    logic [23:0]       mb;
    logic [24:0]       mq;
    logic signed [9:0] e;
    logic              s;
    logic              za;
    logic              zb;
    logic              known;
    logic [31:0]       res_c;
    logic [2:0]        flg_c;
    logic              v1;
    logic [31:0]       r1;
    logic [2:0]        f1;

    // Single-precision mul (op 2) and div (op 3), truncating, flush-to-zero
    always_comb begin
        s     = operand_a[31] ^ operand_b[31];
        za    = operand_a[30:23] == '0;
        zb    = operand_b[30:23] == '0;
        ma    = {1'b1, operand_a[22:0]};
        mb    = {1'b1, operand_b[22:0]};
        known = operation == 4'd2 || operation == 4'd3;
        flg_c = '0;
        if (operation[0]) begin
            mq = 25'({ma, 24'b0} / 48'(mb));
            e  = 10'(operand_a[30:23]) - 10'(operand_b[30:23])
               + 10'd126 + 10'(mq[24]);
        end else begin
            mq = 25'((48'(ma) * 48'(mb)) >> 23);
            e  = 10'(operand_a[30:23]) + 10'(operand_b[30:23])
               - 10'd127 + 10'(mq[24]);
        end
        if (operation[0] && zb) begin
            res_c    = {s, 8'hFF, 23'b0};
            flg_c[2] = 1'b1;
        end else if (za || zb) begin
            res_c = {s, 31'b0};
        end else if (e >= 10'sd255) begin
            res_c    = {s, 8'hFF, 23'b0};
            flg_c[0] = 1'b1;
        end else if (e <= 10'sd0) begin
            res_c    = {s, 31'b0};
            flg_c[1] = 1'b1;
        end else begin
            res_c = {s, e[7:0], mq[24] ? mq[23:1] : mq[22:0]};
        end
    end

    // Two-cycle latency pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            r1          <= '0;
            f1          <= '0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            v1   <= start && known;
            done <= v1;
            if (start && known) begin
                r1 <= res_c;
                f1 <= flg_c;
            end
            if (v1) begin
                result      <= r1;
                div_by_zero <= f1[2];
                underflow   <= f1[1];
                overflow    <= f1[0];
            end
        end
    end
endmodule

module calc_cmd_queue #(
    parameter int CMD_DEPTH = 8,
    parameter int RES_DEPTH = 8,
    parameter int TAG_W     = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_operand_a,
    input  logic [31:0]                  in_operand_b,
    input  logic [3:0]                   in_operation,
    input  logic                         in_mode,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_result,
    output logic [TAG_W-1:0]             out_tag,
    output logic [3:0]                   out_flags,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count,
    output logic [$clog2(RES_DEPTH):0]   res_count,
    output logic                         busy
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       op;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef struct packed {
        logic [31:0]      result;
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
    } res_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    cmd_t          cmd_mem [CMD_DEPTH];
    res_t          res_mem [RES_DEPTH];
    logic [CAW:0]  cmd_wptr, cmd_rptr;
    logic [RAW:0]  res_wptr, res_rptr;
    logic          cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic          res_full, res_empty, res_push, res_pop;
    state_t        state_q, state_d;
    cmd_t          cur_q;
    res_t          cap_q, cap_d, head;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          fx_start, fp_start, alu_rst;
    logic          fx_done, fx_dz, fx_uf, fx_of;
    logic          fp_done, fp_dz, fp_uf, fp_of;
    logic [31:0]   fx_res, fp_res;
    logic          sel_done, sel_dz, sel_uf, sel_of;
    logic [31:0]   sel_res;

    assign alu_rst   = ~reset_n;
    assign cmd_empty = cmd_wptr == cmd_rptr;
    assign cmd_full  = (cmd_wptr[CAW] != cmd_rptr[CAW]) &&
                       (cmd_wptr[CAW-1:0] == cmd_rptr[CAW-1:0]);
    assign res_empty = res_wptr == res_rptr;
    assign res_full  = (res_wptr[RAW] != res_rptr[RAW]) &&
                       (res_wptr[RAW-1:0] == res_rptr[RAW-1:0]);
    assign in_ready  = !cmd_full;
    assign cmd_push  = in_valid && !cmd_full;
    assign out_valid = !res_empty;
    assign res_pop   = out_valid && out_ready;
    assign cmd_count = cmd_wptr - cmd_rptr;
    assign res_count = res_wptr - res_rptr;
    assign busy      = state_q != IDLE;

    // Gate the show-ahead head so outputs are zero while empty
    assign head       = res_mem[res_rptr[RAW-1:0]];
    assign out_result = res_empty ? '0 : head.result;
    assign out_tag    = res_empty ? '0 : head.tag;
    assign out_flags  = res_empty ? '0 : head.flags;

    assign sel_done = cur_q.mode ? fp_done : fx_done;
    assign sel_res  = cur_q.mode ? fp_res  : fx_res;
    assign sel_dz   = cur_q.mode ? fp_dz   : fx_dz;
    assign sel_uf   = cur_q.mode ? fp_uf   : fx_uf;
    assign sel_of   = cur_q.mode ? fp_of   : fx_of;

    // FIFO storage, no reset needed behind the pointers
    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wptr[CAW-1:0]] <= {in_operand_a, in_operand_b,
                                           in_operation, in_mode, in_tag};
        if (res_push)
            res_mem[res_wptr[RAW-1:0]] <= cap_q;
    end

    // Pointers, FSM state and in-flight command registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            res_wptr <= '0;
            res_rptr <= '0;
            state_q  <= IDLE;
            cur_q    <= '0;
            cap_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + 1'b1;
            if (cmd_pop)  cmd_rptr <= cmd_rptr + 1'b1;
            if (res_push) res_wptr <= res_wptr + 1'b1;
            if (res_pop)  res_rptr <= res_rptr + 1'b1;
            if (cmd_pop)  cur_q    <= cmd_mem[cmd_rptr[CAW-1:0]];
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dispatcher: issue, wait for done or timeout, write back
    always_comb begin
        state_d  = state_q;
        cmd_pop  = 1'b0;
        res_push = 1'b0;
        fx_start = 1'b0;
        fp_start = 1'b0;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        unique case (state_q)
            IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fx_start = !cur_q.mode;
                fp_start = cur_q.mode;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (sel_done) begin
                    cap_d.result = sel_res;
                    cap_d.flags  = {1'b0, sel_dz, sel_uf, sel_of};
                    cap_d.tag    = cur_q.tag;
                    state_d      = WRITE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    cap_d.result = '0;
                    cap_d.flags  = 4'b1000;
                    cap_d.tag    = cur_q.tag;
                    state_d      = WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                if (!res_full) begin
                    res_push = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fixed_alu u_fixed (
        .clk         (clk),
        .rst         (alu_rst),
        .start       (fx_start),
        .operand_a   (cur_q.a),
        .operand_b   (cur_q.b),
        .operation   (cur_q.op),
        .done        (fx_done),
        .result      (fx_res),
        .div_by_zero (fx_dz),
        .underflow   (fx_uf),
        .overflow    (fx_of)
    );

    fp_alu u_fp (
        .clk         (clk),
        .rst         (alu_rst),
        .start       (fp_start),
        .operand_a   (cur_q.a),
        .operand_b   (cur_q.b),
        .operation   (cur_q.op),
        .done        (fp_done),
        .result      (fp_res),
        .div_by_zero (fp_dz),
        .underflow   (fp_uf),
        .overflow    (fp_of)
    );
endmodule
